// File: rtl/log_posterior_accumulator_if.sv
// ----------------------------------------------------------------------------
// log_posterior_accumulator_if
// Groups the handshake and data signals of the log-posterior accumulator.
//   start      : one-cycle pulse that begins a new inference
//   in_valid   : proba_in carries one observation
//   in_ready   : accumulator accepts an observation this cycle
//   proba_in   : N_CLASS packed M-bit log-likelihood terms, class c at [c*M +: M]
//   out_valid  : final sums and winner are available
//   out_ready  : consumer takes the result
//   sum_out    : N_CLASS packed M-bit accumulated sums
//   sat_flags  : bit c set when class c saturated during this inference
//   winner     : index of the class with the smallest sum
// The slave modport is the accumulator side. The master modport is the
// producer/consumer side.
// ----------------------------------------------------------------------------
interface log_posterior_accumulator_if #(
  parameter int M       = 8,
  parameter int N_CLASS = 4
);
  localparam int WW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

  logic                   start;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_CLASS*M-1:0]   proba_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_CLASS*M-1:0]   sum_out;
  logic [N_CLASS-1:0]     sat_flags;
  logic [WW-1:0]          winner;

  modport master (
    output start, in_valid, proba_in, out_ready,
    input  in_ready, out_valid, sum_out, sat_flags, winner
  );

  modport slave (
    input  start, in_valid, proba_in, out_ready,
    output in_ready, out_valid, sum_out, sat_flags, winner
  );
endinterface

// File: rtl/log_posterior_accumulator.sv
// ----------------------------------------------------------------------------
// log_posterior_accumulator
// Accumulates N_OBS log-likelihood terms per class for N_CLASS classes in
// parallel. Every addition saturates to all-ones, and a per-class sticky flag
// records whether saturation occurred. After the last observation the block
// presents the sums, the flags and the index of the smallest sum through a
// valid/ready handshake.
//   clk : clock. All state changes on the rising edge.
//   rst : synchronous, active-high reset. It returns the block to IDLE and
//         clears all state.
//   bus : log_posterior_accumulator_if.slave. The signal descriptions are in
//         the interface file.
// Behaviour:
//   IDLE -> ACC on start.
//   ACC accepts beats. A start in ACC restarts the inference and discards any
//   beat presented in the same cycle.
//   ACC -> DONE on the beat that completes the N_OBS-th observation.
//   DONE -> IDLE on out_valid & out_ready. While in DONE, start and in_valid
//   are ignored.
// ----------------------------------------------------------------------------
module log_posterior_accumulator #(
  parameter int M       = 8,
  parameter int N_CLASS = 4,
  parameter int N_OBS   = 4
) (
  input logic                          clk,
  input logic                          rst,
  log_posterior_accumulator_if.slave   bus
);

  localparam int CW = $clog2(N_OBS + 1);
  localparam int WW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [M-1:0]         acc_r   [N_CLASS];
  logic [M-1:0]         acc_s   [N_CLASS];
  logic [N_CLASS-1:0]   sat_r;
  logic [N_CLASS-1:0]   sat_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_s;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 clear_s;
  logic                 acc_en_s;
  logic [M:0]           sum_w_s;
  logic [N_CLASS*M-1:0] sum_flat_s;
  logic [M-1:0]         best_val_s;
  logic [WW-1:0]        best_idx_s;

  // Saturating add. Bit M of the result is the saturation indicator, and the
  // low M bits hold the clamped sum.
  function automatic logic [M:0] sat_add(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[M]) begin
      sat_add = {1'b1, {M{1'b1}}};
    end else begin
      sat_add = {1'b0, s[M-1:0]};
    end
  endfunction

  // Next-state logic. This block also decides whether to clear the
  // accumulators or to accept a beat.
  always_comb begin
    state_s  = state_r;
    clear_s  = 1'b0;
    acc_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          clear_s = 1'b1;
          state_s = ACC;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        // A restart takes priority over a beat in the same cycle.
        if (bus.start) begin
          clear_s = 1'b1;
          state_s = ACC;
        end else if (bus.in_valid) begin
          acc_en_s = 1'b1;
          if (cnt_r == CW'(N_OBS - 1)) begin
            state_s = DONE;
          end else begin
            state_s = ACC;
          end
        end else begin
          state_s = ACC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Accumulator, sticky-flag and observation-counter update.
  always_comb begin
    acc_s   = acc_r;
    sat_s   = sat_r;
    cnt_s   = cnt_r;
    sum_w_s = {(M + 1){1'b0}};
    if (clear_s) begin
      for (int c = 0; c < N_CLASS; c++) begin
        acc_s[c] = {M{1'b0}};
      end
      sat_s = {N_CLASS{1'b0}};
      cnt_s = {CW{1'b0}};
    end else if (acc_en_s) begin
      for (int c = 0; c < N_CLASS; c++) begin
        sum_w_s  = sat_add(acc_r[c], bus.proba_in[c*M +: M]);
        acc_s[c] = sum_w_s[M-1:0];
        sat_s[c] = sat_r[c] | sum_w_s[M];
      end
      cnt_s = cnt_r + CW'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State, datapath and handshake-output registers. The handshake outputs
  // are registered from the next state, so they have no combinational path
  // from in_valid or out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sat_r       <= {N_CLASS{1'b0}};
      cnt_r       <= {CW{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      for (int c = 0; c < N_CLASS; c++) begin
        acc_r[c] <= {M{1'b0}};
      end
    end else begin
      state_r     <= state_s;
      sat_r       <= sat_s;
      cnt_r       <= cnt_s;
      in_ready_r  <= (state_s == ACC);
      out_valid_r <= (state_s == DONE);
      for (int c = 0; c < N_CLASS; c++) begin
        acc_r[c] <= acc_s[c];
      end
    end
  end

  // Minimum search over the registered sums. The strict less-than keeps the
  // lowest index when sums tie.
  always_comb begin
    best_val_s = acc_r[0];
    best_idx_s = {WW{1'b0}};
    for (int c = 1; c < N_CLASS; c++) begin
      if (acc_r[c] < best_val_s) begin
        best_val_s = acc_r[c];
        best_idx_s = WW'(c);
      end else begin
        best_val_s = best_val_s;
      end
    end
  end

  // Packing of the per-class accumulators onto the flat output bus.
  always_comb begin
    sum_flat_s = {(N_CLASS * M){1'b0}};
    for (int c = 0; c < N_CLASS; c++) begin
      sum_flat_s[c*M +: M] = acc_r[c];
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum_out   = sum_flat_s;
  assign bus.sat_flags = sat_r;
  assign bus.winner    = best_idx_s;

endmodule

// File: tb/tb_log_posterior_accumulator.sv
// ----------------------------------------------------------------------------
// tb_log_posterior_accumulator
// Directed, self-checking bench. A reference model of the saturating
// accumulation pushes the expected sums, flags and winner into a scoreboard
// queue when an inference completes. The entry is popped and compared when
// the DUT raises out_valid.
// ----------------------------------------------------------------------------
module tb_log_posterior_accumulator;

  localparam int M       = 8;
  localparam int N_CLASS = 4;
  localparam int N_OBS   = 4;

  typedef struct {
    logic [N_CLASS*M-1:0] sums;
    logic [N_CLASS-1:0]   flags;
    logic [1:0]           win;
  } exp_t;

  logic clk;
  logic rst;
  int   total_checks;
  int   passed_checks;

  exp_t         sb[$];
  logic [M-1:0] m_acc [N_CLASS];
  logic [N_CLASS-1:0] m_sat;
  int           m_cnt;

  log_posterior_accumulator_if #(.M(M), .N_CLASS(N_CLASS)) bus ();

  log_posterior_accumulator #(.M(M), .N_CLASS(N_CLASS), .N_OBS(N_OBS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "time limit expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_checks = total_checks + 1;
    assert (obs === expv) passed_checks = passed_checks + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic [N_CLASS*M-1:0] pack4(input logic [M-1:0] a, input logic [M-1:0] b,
                                                 input logic [M-1:0] c, input logic [M-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N_CLASS; c++) m_acc[c] = '0;
    m_sat = '0;
    m_cnt = 0;
  endtask

  // Reference model of one accepted beat. When the inference completes it
  // pushes the expected result into the scoreboard.
  task automatic model_beat(input logic [N_CLASS*M-1:0] v);
    logic [M:0] s;
    exp_t e;
    for (int c = 0; c < N_CLASS; c++) begin
      s = {1'b0, m_acc[c]} + {1'b0, v[c*M +: M]};
      if (s[M]) begin
        m_acc[c] = 8'hFF;
        m_sat[c] = 1'b1;
      end else begin
        m_acc[c] = s[M-1:0];
      end
    end
    m_cnt++;
    if (m_cnt == N_OBS) begin
      e.sums  = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
      e.flags = m_sat;
      e.win   = 2'd0;
      for (int c = 1; c < N_CLASS; c++)
        if (m_acc[c] < m_acc[e.win]) e.win = 2'(c);
      sb.push_back(e);
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    model_clear();
  endtask

  task automatic beat(input logic [N_CLASS*M-1:0] v);
    bus.in_valid = 1'b1;
    bus.proba_in = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model_beat(v);
  endtask

  // Waits a bounded number of cycles for out_valid, compares the result
  // against the scoreboard, and then completes the handshake.
  task automatic expect_out(input string tag, input int max_wait);
    int   n;
    exp_t e;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < max_wait) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid_wait"}, 64'(n), 64'd0);
    check({tag, "_in_ready_done"}, 64'(bus.in_ready), 64'd0);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_sums"}, 64'(bus.sum_out), 64'(e.sums));
      check({tag, "_flags"}, 64'(bus.sat_flags), 64'(e.flags));
      check({tag, "_winner"}, 64'(bus.winner), 64'(e.win));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle_after_hs"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [N_CLASS*M-1:0] held;
    clk = 1'b0;
    rst = 1'b1;
    total_checks = 0;
    passed_checks = 0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.proba_in = '0;
    bus.out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum_out", 64'(bus.sum_out), 64'd0);
    check("rst_sat_flags", 64'(bus.sat_flags), 64'd0);
    check("rst_winner", 64'(bus.winner), 64'd0);

    // Basic sum
    do_start();
    check("basic_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < N_OBS; i++) beat(pack4(8'd10, 8'd20, 8'd30, 8'd40));
    check("basic_latency", 64'(bus.out_valid), 64'd1);
    check("basic_sums_const", 64'(bus.sum_out), 64'(pack4(8'd40, 8'd80, 8'd120, 8'd160)));
    expect_out("basic", 8);

    // Saturation on class 1
    do_start();
    beat(pack4(8'd1, 8'd200, 8'd1, 8'd1));
    beat(pack4(8'd1, 8'd100, 8'd1, 8'd1));
    beat(pack4(8'd1, 8'd0,   8'd1, 8'd1));
    beat(pack4(8'd1, 8'd5,   8'd1, 8'd1));
    check("sat1_flags_const", 64'(bus.sat_flags), 64'h2);
    check("sat1_sums_const", 64'(bus.sum_out), 64'(pack4(8'd4, 8'd255, 8'd4, 8'd4)));
    expect_out("sat1", 8);

    // Class 0 reaches all-ones without a carry
    do_start();
    beat(pack4(8'd255, 8'd3, 8'd3, 8'd3));
    beat(pack4(8'd0,   8'd3, 8'd3, 8'd3));
    beat(pack4(8'd0,   8'd3, 8'd3, 8'd3));
    beat(pack4(8'd0,   8'd3, 8'd3, 8'd3));
    expect_out("sat0", 8);

    // Tie: all terms zero
    do_start();
    for (int i = 0; i < N_OBS; i++) beat('0);
    expect_out("tie_zero", 8);

    // Tie: classes 2 and 3 both at 7
    do_start();
    beat(pack4(8'd5, 8'd5, 8'd7, 8'd0));
    beat(pack4(8'd5, 8'd5, 8'd0, 8'd7));
    beat(pack4(8'd0, 8'd0, 8'd0, 8'd0));
    beat(pack4(8'd0, 8'd0, 8'd0, 8'd0));
    check("tie23_winner_const", 64'(bus.winner), 64'd2);
    expect_out("tie23", 8);

    // Backpressure: in_valid and start are ignored while in DONE
    do_start();
    for (int i = 0; i < N_OBS; i++) beat(pack4(8'd9, 8'd8, 8'd7, 8'd6));
    held = bus.sum_out;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.proba_in = pack4(8'd99, 8'd99, 8'd99, 8'd99);
      bus.start = (i % 2 == 0);
      @(posedge clk); #1;
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_sum_hold", 64'(bus.sum_out), 64'(pack4(8'd36, 8'd32, 8'd28, 8'd24)));
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    check("bp_held_first", 64'(held), 64'(pack4(8'd36, 8'd32, 8'd28, 8'd24)));
    expect_out("bp", 8);

    // Restart: a start in ACC together with a beat discards the beat
    do_start();
    beat(pack4(8'd50, 8'd50, 8'd50, 8'd50));
    beat(pack4(8'd50, 8'd50, 8'd50, 8'd50));
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.proba_in = pack4(8'd50, 8'd50, 8'd50, 8'd50);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    check("restart_sum_clear", 64'(bus.sum_out), 64'd0);
    check("restart_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < N_OBS; i++) beat(pack4(8'd50, 8'd50, 8'd50, 8'd50));
    check("restart_sums_const", 64'(bus.sum_out), 64'(pack4(8'd200, 8'd200, 8'd200, 8'd200)));
    expect_out("restart", 8);

    // Reset in the middle of an accumulation
    do_start();
    beat(pack4(8'd77, 8'd66, 8'd55, 8'd44));
    beat(pack4(8'd77, 8'd66, 8'd55, 8'd44));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_sum_out", 64'(bus.sum_out), 64'd0);
    check("midrst_sat_flags", 64'(bus.sat_flags), 64'd0);
    check("midrst_winner", 64'(bus.winner), 64'd0);
    do_start();
    for (int i = 0; i < N_OBS; i++) beat(pack4(8'd4, 8'd3, 8'd2, 8'd1));
    check("postrst_sums_const", 64'(bus.sum_out), 64'(pack4(8'd16, 8'd12, 8'd8, 8'd4)));
    expect_out("postrst", 8);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
